// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM driving a shared-ALU, shared-memory datapath.
// Optional macro CU_BNE_EN adds bne (branch funct3 001) support.
module multicycle_control_unit #(
  parameter int unsigned ALUCTL_W = 3,
  parameter bit          MEM_HS   = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          op,
  input  logic [2:0]          funct3,
  input  logic                funct7b5,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                AdrSrc,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic [1:0]          ResultSrc,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ImmSrc,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic                RegWrite,
  output logic                illegal_op,
  output logic [3:0]          state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t     state_q, state_d;
  logic       ready;
  logic [2:0] alu3;

  assign ready = MEM_HS ? mem_ready : 1'b1;
  assign state = state_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    illegal_op = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ImmSrc     = 2'b00;
    alu3       = 3'b000;

    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase

    case (state_q)
      S_FETCH: begin
        ResultSrc = 2'b10;
        ALUSrcB   = 2'b10;
        if (ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ: begin
            if (funct3 == 3'b000)      state_d = S_BRANCH;
`ifdef CU_BNE_EN
            else if (funct3 == 3'b001) state_d = S_BRANCH;
`endif
            else                       state_d = S_ILLEGAL;
          end
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (ready) state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        case (funct3)
          3'b000:  alu3 = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu3 = 3'b101;
          3'b110:  alu3 = 3'b011;
          3'b111:  alu3 = 3'b010;
          default: alu3 = 3'b000;
        endcase
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        alu3    = 3'b001;
`ifdef CU_BNE_EN
        PCWrite = (funct3 == 3'b001) ? ~zero : zero;
`else
        PCWrite = zero;
`endif
        state_d = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_ILLEGAL: begin
        illegal_op = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset squashes every strobe and select combinationally, so an access in flight is abandoned.
    if (reset) begin
      state_d    = S_FETCH;
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      illegal_op = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ImmSrc     = 2'b00;
      alu3       = 3'b000;
    end

    ALUControl      = '0;
    ALUControl[2:0] = alu3;
  end

endmodule
